wb_stage: RTL and testbench

Writeback stage of the five-stage MIPS pipeline, directly upstream of the register file write port. Latches the MEM-stage result into a pipeline register and handles the valid/allowin handshake and stall holding. Extracts and extends load data from the data SRAM, then drives one register-file write per retired instruction.

---
 rtl/wb_stage_if.sv | 20 ++
 rtl/wb_stage.sv | 112 +++++++++++
 tb/tb_wb_stage.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM -> WB pipeline bus: valid/allowin handshake plus the instruction payload.
interface wb_stage_if;
    logic        mem_valid;
    logic        wb_allowin;
    logic [31:0] mem_pc;
    logic        mem_reg_write;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_result;
    logic [2:0]  mem_load;

    modport master (
        output mem_valid, mem_pc, mem_reg_write, mem_waddr, mem_result, mem_load,
        input  wb_allowin
    );

    modport slave (
        input  mem_valid, mem_pc, mem_reg_write, mem_waddr, mem_result, mem_load,
        output wb_allowin
    );
endinterface

// File: rtl/wb_stage.sv
// MIPS writeback stage: WB pipeline register, load extraction, register-file write.
// Optional trace ports under `define WB_TRACE_EN.
module wb_stage (
    input  logic        clk,
    input  logic        rstn,
    wb_stage_if.slave   mem,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_stall,
    output logic        reg_write,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        wb_valid,
    output logic [4:0]  wb_fwd_waddr,
    output logic [31:0] wb_fwd_wdata
`ifdef WB_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`endif
);

    localparam logic [2:0] LD_LW  = 3'd1;
    localparam logic [2:0] LD_LB  = 3'd2;
    localparam logic [2:0] LD_LBU = 3'd3;
    localparam logic [2:0] LD_LH  = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic        reg_write;
        logic [4:0]  waddr;
        logic [31:0] result;
        logic [2:0]  load;
    } wb_req_t;

    wb_req_t     wb_r;
    logic        first_cycle;
    logic [31:0] rdata_buf;
    logic        allowin;
    logic        mem_is_load;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] wb_data;

    assign allowin        = !wb_valid || !wb_stall;
    assign mem.wb_allowin = allowin;
    assign mem_is_load    = (mem.mem_load >= LD_LW) && (mem.mem_load <= LD_LHU);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid    <= 1'b0;
            wb_r        <= '0;
            first_cycle <= 1'b0;
            rdata_buf   <= '0;
        end else begin
            // SRAM data is only guaranteed in the first WB cycle of a load.
            if (first_cycle)
                rdata_buf <= data_sram_rdata;
            if (allowin) begin
                wb_valid    <= mem.mem_valid;
                first_cycle <= mem.mem_valid && mem_is_load;
                if (mem.mem_valid)
                    wb_r <= '{pc:        mem.mem_pc,
                              reg_write: mem.mem_reg_write,
                              waddr:     mem.mem_waddr,
                              result:    mem.mem_result,
                              load:      mem.mem_load};
            end else begin
                first_cycle <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_word = first_cycle ? data_sram_rdata : rdata_buf;
        case (wb_r.result[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = wb_r.result[1] ? rd_word[31:16] : rd_word[15:0];
        case (wb_r.load)
            LD_LW:   wb_data = rd_word;
            LD_LB:   wb_data = {{24{rd_byte[7]}}, rd_byte};
            LD_LBU:  wb_data = {24'h0, rd_byte};
            LD_LH:   wb_data = {{16{rd_half[15]}}, rd_half};
            LD_LHU:  wb_data = {16'h0, rd_half};
            default: wb_data = wb_r.result;
        endcase
    end

    assign reg_write    = wb_valid && !wb_stall && wb_r.reg_write && (wb_r.waddr != 5'd0);
    assign waddr        = wb_valid ? wb_r.waddr : 5'd0;
    assign wdata        = wb_valid ? wb_data : 32'd0;
    assign wb_fwd_waddr = (wb_valid && wb_r.reg_write) ? wb_r.waddr : 5'd0;
    assign wb_fwd_wdata = wdata;

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = wb_r.pc;
    assign debug_wb_rf_wen   = {4{reg_write}};
    assign debug_wb_rf_wnum  = waddr;
    assign debug_wb_rf_wdata = wdata;
`else
    logic unused_pc;
    assign unused_pc = ^wb_r.pc;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected RF writes queued at issue, checked at commit.
module tb_wb_stage;

    logic        clk;
    logic        rstn;
    logic [31:0] data_sram_rdata;
    logic        wb_stall;
    logic        reg_write;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wb_valid;
    logic [4:0]  wb_fwd_waddr;
    logic [31:0] wb_fwd_wdata;
`ifdef WB_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    wb_stage_if mif ();

    wb_stage dut (
        .clk             (clk),
        .rstn            (rstn),
        .mem             (mif.slave),
        .data_sram_rdata (data_sram_rdata),
        .wb_stall        (wb_stall),
        .reg_write       (reg_write),
        .waddr           (waddr),
        .wdata           (wdata),
        .wb_valid        (wb_valid),
        .wb_fwd_waddr    (wb_fwd_waddr),
        .wb_fwd_wdata    (wb_fwd_wdata)
`ifdef WB_TRACE_EN
        ,
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference extraction written as shifts rather than a byte/half mux.
    function automatic logic [31:0] model(input logic [2:0] ld, input logic [31:0] res,
                                          input logic [31:0] rd);
        logic [31:0] sb_w, sh_w;
        sb_w = rd >> (8 * res[1:0]);
        sh_w = rd >> (16 * res[1]);
        case (ld)
            3'd1:    return rd;
            3'd2:    return {{24{sb_w[7]}}, sb_w[7:0]};
            3'd3:    return {24'h0, sb_w[7:0]};
            3'd4:    return {{16{sh_w[15]}}, sh_w[15:0]};
            3'd5:    return {16'h0, sh_w[15:0]};
            default: return res;
        endcase
    endfunction

    // Presents one instruction, waits for the accepting edge, then supplies its SRAM word.
    task automatic send(input logic [31:0] pc, input logic rw, input logic [4:0] wa,
                        input logic [31:0] res, input logic [2:0] ld, input logic [31:0] rd,
                        input logic [31:0] exp_wd, input bit push);
        wr_t e;
        mif.mem_valid     = 1'b1;
        mif.mem_pc        = pc;
        mif.mem_reg_write = rw;
        mif.mem_waddr     = wa;
        mif.mem_result    = res;
        mif.mem_load      = ld;
        if (push) begin
            e.wa = wa;
            e.wd = exp_wd;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        mif.mem_valid   = 1'b0;
        data_sram_rdata = rd;
    endtask

    always @(negedge clk) begin
        if (reg_write) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {27'h0, waddr}, 32'h0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("sb_waddr", {27'h0, waddr}, {27'h0, e.wa});
                chk("sb_wdata", wdata, e.wd);
                chk("fwd_wdata", wb_fwd_wdata, e.wd);
                chk("fwd_waddr", {27'h0, wb_fwd_waddr}, {27'h0, e.wa});
            end
        end
    end

    initial begin
        logic [2:0]  ld;
        logic [4:0]  wa;
        logic        rw;
        logic [31:0] res, rd;

        rstn = 1'b0;
        wb_stall = 1'b0;
        data_sram_rdata = '0;
        mif.mem_valid = 1'b0;
        mif.mem_pc = '0;
        mif.mem_reg_write = 1'b0;
        mif.mem_waddr = '0;
        mif.mem_result = '0;
        mif.mem_load = '0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid",     {31'h0, wb_valid}, 32'h0);
        chk("rst_wen",       {31'h0, reg_write}, 32'h0);
        chk("rst_waddr",     {27'h0, waddr}, 32'h0);
        chk("rst_wdata",     wdata, 32'h0);
        chk("rst_fwd_waddr", {27'h0, wb_fwd_waddr}, 32'h0);
        chk("rst_fwd_wdata", wb_fwd_wdata, 32'h0);
        chk("rst_allowin",   {31'h0, mif.wb_allowin}, 32'h1);
        rstn = 1'b1;

        wb_stall = 1'b1;
        #1 chk("bubble_stall_allowin", {31'h0, mif.wb_allowin}, 32'h1);
        wb_stall = 1'b0;
        @(negedge clk);

        // ADD r5: write visible in the cycle after acceptance, gone the cycle after.
        send(32'h100, 1'b1, 5'd5, 32'h0000_1234, 3'd0, 32'h0, 32'h0000_1234, 1'b1);
        #1;
        chk("add_wen",   {31'h0, reg_write}, 32'h1);
        chk("add_waddr", {27'h0, waddr}, 32'd5);
        chk("add_wdata", wdata, 32'h0000_1234);
        @(posedge clk);
        #2;
        chk("add_wen_after", {31'h0, reg_write}, 32'h0);
        chk("add_valid_after", {31'h0, wb_valid}, 32'h0);

        // Back-to-back loads.
        send(32'h104, 1'b1, 5'd6,  32'h0000_1003, 3'd2, 32'h80FF_0011, 32'hFFFF_FF80, 1'b1);
        send(32'h108, 1'b1, 5'd7,  32'h0000_1003, 3'd3, 32'h80FF_0011, 32'h0000_0080, 1'b1);
        send(32'h10c, 1'b1, 5'd8,  32'h0000_1002, 3'd4, 32'h8001_7FFF, 32'hFFFF_8001, 1'b1);
        send(32'h110, 1'b1, 5'd9,  32'h0000_1000, 3'd5, 32'h8001_7FFF, 32'h0000_7FFF, 1'b1);
        send(32'h114, 1'b1, 5'd10, 32'h0000_2000, 3'd2, 32'h80FF_0011, 32'h0000_0011, 1'b1);
        send(32'h118, 1'b1, 5'd11, 32'h0000_2002, 3'd2, 32'h80FF_0011, 32'hFFFF_FFFF, 1'b1);
        send(32'h11c, 1'b1, 5'd12, 32'h0000_2000, 3'd1, 32'h80FF_0011, 32'h80FF_0011, 1'b1);
        send(32'h120, 1'b1, 5'd13, 32'h0000_ABCD, 3'd6, 32'h1111_1111, 32'h0000_ABCD, 1'b1);
        @(posedge clk);
        #1;

        // Stalled LW: SRAM word disappears after the first cycle; junk on MEM is ignored.
        send(32'h200, 1'b1, 5'd7, 32'h0000_0200, 3'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        wb_stall = 1'b1;
        mif.mem_valid = 1'b1;
        mif.mem_reg_write = 1'b1;
        mif.mem_waddr = 5'd9;
        mif.mem_result = 32'h55;
        mif.mem_load = 3'd0;
        #1;
        chk("stall1_allowin", {31'h0, mif.wb_allowin}, 32'h0);
        chk("stall1_wen",     {31'h0, reg_write}, 32'h0);
        chk("stall1_fwd",     {27'h0, wb_fwd_waddr}, 32'd7);
        chk("stall1_wdata",   wdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        data_sram_rdata = 32'h0;
        #1;
        chk("stall2_wdata",   wdata, 32'hDEAD_BEEF);
        chk("stall2_wen",     {31'h0, reg_write}, 32'h0);
        @(posedge clk);
        #2;
        chk("stall3_allowin", {31'h0, mif.wb_allowin}, 32'h0);
        chk("stall3_wen",     {31'h0, reg_write}, 32'h0);
        @(posedge clk);
        #1;
        wb_stall = 1'b0;
        mif.mem_valid = 1'b0;
        #1;
        chk("release_wen",   {31'h0, reg_write}, 32'h1);
        chk("release_wdata", wdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #2;
        chk("release_after_wen", {31'h0, reg_write}, 32'h0);

        // Write to r0 is suppressed and not forwarded.
        send(32'h300, 1'b1, 5'd0, 32'hFFFF_FFFF, 3'd0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("r0_valid", {31'h0, wb_valid}, 32'h1);
        chk("r0_wen",   {31'h0, reg_write}, 32'h0);
        chk("r0_fwd",   {27'h0, wb_fwd_waddr}, 32'h0);
        @(posedge clk);
        #1;

        // Random back-to-back burst.
        for (int i = 0; i < 24; i++) begin
            ld  = 3'($urandom_range(0, 7));
            wa  = 5'($urandom_range(0, 31));
            rw  = 1'($urandom_range(0, 1));
            res = $urandom;
            rd  = $urandom;
            send(32'h400 + 32'(4 * i), rw, wa, res, ld, rd, model(ld, res, rd),
                 rw && (wa != 5'd0));
        end
        @(posedge clk);
        #1;

        // Reset during a stalled LW to r3 discards it.
        send(32'h500, 1'b1, 5'd3, 32'h0000_0300, 3'd1, 32'h1234_5678, 32'h0, 1'b0);
        wb_stall = 1'b1;
        #1;
        chk("rst_pre_valid", {31'h0, wb_valid}, 32'h1);
        chk("rst_pre_wen",   {31'h0, reg_write}, 32'h0);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_mid_wen",   {31'h0, reg_write}, 32'h0);
        chk("rst_mid_wdata", wdata, 32'h0);
        chk("rst_mid_fwd",   {27'h0, wb_fwd_waddr}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("rst_rel_allowin", {31'h0, mif.wb_allowin}, 32'h1);
        wb_stall = 1'b0;

        send(32'h600, 1'b1, 5'd1, 32'h0000_0077, 3'd0, 32'h0, 32'h0000_0077, 1'b1);
        @(posedge clk);
        #2;
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
